// File: rtl/rom_arbiter_23128_if.sv
// rom_arbiter_23128_if: requester ports and 23128 ROM pins.
// slave = arbiter side, master = requesters plus the ROM.
interface rom_arbiter_23128_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic              p0_done;
  logic [DATA_W-1:0] p0_rdata;
  logic              p1_req;
  logic [ADDR_W-1:0] p1_addr;
  logic              p1_done;
  logic [DATA_W-1:0] p1_rdata;
  logic [ADDR_W-1:0] rom_A;
  logic              rom_CS_b;
  logic              rom_OE_b;
  logic              rom_CE1_b;
  logic              rom_CE2_b;
  logic [DATA_W-1:0] rom_D;
  logic              busy;

  modport slave (
    input  p0_req, p0_addr, p1_req, p1_addr, rom_D,
    output p0_done, p0_rdata, p1_done, p1_rdata,
    output rom_A, rom_CS_b, rom_OE_b, rom_CE1_b, rom_CE2_b,
    output busy
  );

  modport master (
    output p0_req, p0_addr, p1_req, p1_addr, rom_D,
    input  p0_done, p0_rdata, p1_done, p1_rdata,
    input  rom_A, rom_CS_b, rom_OE_b, rom_CE1_b, rom_CE2_b,
    input  busy
  );
endinterface

// File: rtl/rom_arbiter_23128.sv
// rom_arbiter_23128: two-port sequencer/arbiter for a 23128 ROM.
// ROM_ARB_RR_EN selects round-robin; undefined gives port-0 priority.
module rom_arbiter_23128 #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 8
) (
  input logic clk,
  input logic rst,
  rom_arbiter_23128_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, DONE
  } state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic              owner;
  logic              win;
  logic              grant;
  logic              cap;
  logic              cs_b, oe_b, ce_b;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rd0, rd1;

`ifdef ROM_ARB_RR_EN
  logic last;

  // Winner: lone requester, else the port not served last.
  always_comb begin
    win = bus.p1_req & (~bus.p0_req | ~last);
  end

  // Last-served pointer; reset value makes port 0 favoured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last <= 1'b1;
    else if (grant) last <= win;
  end
`else
  // Winner: port 0 whenever it asks.
  always_comb begin
    win = ~bus.p0_req;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and ROM control strobes.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    cap      = 1'b0;
    cs_b     = 1'b1;
    oe_b     = 1'b1;
    ce_b     = 1'b1;
    unique case (state)
      IDLE: begin
        if (bus.p0_req | bus.p1_req) begin
          grant    = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        cs_b     = 1'b0;
        state_nx = ACCESS;
      end
      ACCESS: begin
        cs_b = 1'b0;
        oe_b = 1'b0;
        ce_b = 1'b0;
        if (cnt == 4'd0) begin
          cap      = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Access wait counter, loaded in SETUP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= 4'd0;
    else if (state == SETUP)
      cnt <= 4'(WAIT_CYCLES - 1);
    else if (state == ACCESS && cnt != 4'd0)
      cnt <= cnt - 4'd1;
  end

  // Latch address and owner on grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      owner  <= 1'b0;
    end else if (grant) begin
      addr_q <= win ? bus.p1_addr : bus.p0_addr;
      owner  <= win;
    end
  end

  // Capture ROM data into the owner's read register only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd0 <= '0;
      rd1 <= '0;
    end else if (cap) begin
      if (owner) rd1 <= bus.rom_D;
      else       rd0 <= bus.rom_D;
    end
  end

  assign bus.rom_A     = addr_q;
  assign bus.rom_CS_b  = cs_b;
  assign bus.rom_OE_b  = oe_b;
  assign bus.rom_CE1_b = ce_b;
  assign bus.rom_CE2_b = ce_b;
  assign bus.p0_done   = (state == DONE) & ~owner;
  assign bus.p1_done   = (state == DONE) & owner;
  assign bus.p0_rdata  = rd0;
  assign bus.p1_rdata  = rd1;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_rom_arbiter_23128.sv
// tb_rom_arbiter_23128: directed checks of the ROM arbiter.
// Three DUTs: WAIT_CYCLES = 2 (main), 1 and 15.
module tb_rom_arbiter_23128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  rom_arbiter_23128_if #(.ADDR_W(14), .DATA_W(8)) bus();
  rom_arbiter_23128_if #(.ADDR_W(14), .DATA_W(8)) bus1();
  rom_arbiter_23128_if #(.ADDR_W(14), .DATA_W(8)) bus15();

  rom_arbiter_23128 #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  rom_arbiter_23128 #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  rom_arbiter_23128 #(.WAIT_CYCLES(15)) dut15 (
    .clk(clk), .rst(rst), .bus(bus15)
  );

  function automatic logic [7:0] mdl(input logic [13:0] a);
    case (a)
      14'h1234: return 8'hA5;
      14'h0010: return 8'h11;
      14'h3FFF: return 8'h22;
      default:  return a[7:0] ^ {2'b00, a[13:8]};
    endcase
  endfunction

  assign bus.rom_D = (!bus.rom_CS_b && !bus.rom_OE_b && !bus.rom_CE1_b)
                   ? mdl(bus.rom_A) : 8'hEE;
  assign bus1.rom_D = (!bus1.rom_CS_b && !bus1.rom_OE_b && !bus1.rom_CE1_b)
                    ? mdl(bus1.rom_A) : 8'hEE;
  assign bus15.rom_D = (!bus15.rom_CS_b && !bus15.rom_OE_b && !bus15.rom_CE1_b)
                     ? mdl(bus15.rom_A) : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_p(input int port, input int budget, output int cyc);
    int n;
    n = 0;
    cyc = -1;
    while (n < budget) begin
      step();
      n++;
      if ((port == 0 && bus.p0_done) || (port == 1 && bus.p1_done)) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic wait_any(input int budget, output int cyc);
    int n;
    n = 0;
    cyc = -1;
    while (n < budget) begin
      step();
      n++;
      if (bus.p0_done || bus.p1_done) begin
        cyc = n;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, lows, l1, l15;
    logic [1:0] exp_w;
    bus.p0_req = 0; bus.p0_addr = '0;
    bus.p1_req = 0; bus.p1_addr = '0;
    bus1.p0_req = 0; bus1.p0_addr = '0;
    bus1.p1_req = 0; bus1.p1_addr = '0;
    bus15.p0_req = 0; bus15.p0_addr = '0;
    bus15.p1_req = 0; bus15.p1_addr = '0;

    do_reset();
    chk("rst_busy", bus.busy, 0);
    chk("rst_cs", bus.rom_CS_b, 1);
    chk("rst_oe", bus.rom_OE_b, 1);
    chk("rst_ce", {bus.rom_CE1_b, bus.rom_CE2_b}, 2'b11);
    chk("rst_addr", bus.rom_A, 0);
    chk("rst_done", {bus.p1_done, bus.p0_done}, 0);
    chk("rst_rd", {bus.p1_rdata, bus.p0_rdata}, 0);

    // single read, cycle 0 = request sampled
    bus.p0_req = 1; bus.p0_addr = 14'h1234;
    step();
    chk("c1_cs", bus.rom_CS_b, 0);
    chk("c1_oe", bus.rom_OE_b, 1);
    chk("c1_ce", bus.rom_CE1_b, 1);
    chk("c1_a", bus.rom_A, 14'h1234);
    chk("c1_busy", bus.busy, 1);
    step();
    chk("c2_ctl", {bus.rom_CS_b, bus.rom_OE_b, bus.rom_CE1_b, bus.rom_CE2_b}, 0);
    chk("c2_done", bus.p0_done, 0);
    step();
    chk("c3_oe", bus.rom_OE_b, 0);
    chk("c3_done", bus.p0_done, 0);
    step();
    chk("c4_done", bus.p0_done, 1);
    chk("c4_p1done", bus.p1_done, 0);
    chk("c4_ctl", {bus.rom_CS_b, bus.rom_OE_b, bus.rom_CE1_b, bus.rom_CE2_b}, 4'hF);
    chk("c4_rd", bus.p0_rdata, 8'hA5);
    chk("c4_rd1", bus.p1_rdata, 0);
    chk("c4_a", bus.rom_A, 14'h1234);
    bus.p0_req = 0;
    step();
    chk("c5_done", bus.p0_done, 0);
    chk("c5_busy", bus.busy, 0);
    chk("c5_a", bus.rom_A, 14'h1234);

    // reset during second ACCESS cycle
    bus.p0_req = 1; bus.p0_addr = 14'h0010;
    step(); step(); step();
    chk("ra_oe", bus.rom_OE_b, 0);
    rst = 1'b1;
    #1;
    chk("ra_ctl", {bus.rom_CS_b, bus.rom_OE_b, bus.rom_CE1_b, bus.rom_CE2_b}, 4'hF);
    chk("ra_busy", bus.busy, 0);
    chk("ra_done", bus.p0_done, 0);
    chk("ra_rd", bus.p0_rdata, 0);
    chk("ra_a", bus.rom_A, 0);
    step();
    chk("ra_done2", bus.p0_done, 0);
    rst = 1'b0;
    wait_p(0, 12, c);
    chk("ra_lat", c, 4);
    chk("ra_rdnew", bus.p0_rdata, 8'h11);
    bus.p0_req = 0;
    step();

    // simultaneous requests, each held until served
    do_reset();
    bus.p0_addr = 14'h0010; bus.p1_addr = 14'h3FFF;
    bus.p0_req = 1; bus.p1_req = 1;
    wait_p(0, 12, c);
    chk("ct_lat0", c, 4);
    chk("ct_p1done", bus.p1_done, 0);
    chk("ct_rd0", bus.p0_rdata, 8'h11);
    chk("ct_rd1a", bus.p1_rdata, 0);
    bus.p0_req = 0;
    wait_p(1, 12, c);
    chk("ct_gap1", c, 5);
    chk("ct_rd1", bus.p1_rdata, 8'h22);
    chk("ct_rd0b", bus.p0_rdata, 8'h11);
    bus.p1_req = 0;
    step();

    // both requests held continuously: arbitration order
    do_reset();
    bus.p0_addr = 14'h0100; bus.p1_addr = 14'h0200;
    bus.p0_req = 1; bus.p1_req = 1;
    for (int i = 0; i < 3; i++) begin
      wait_any(12, c);
      chk($sformatf("arb_lat%0d", i), c, (i == 0) ? 4 : 5);
`ifdef ROM_ARB_RR_EN
      exp_w = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_w = 2'b01;
`endif
      chk($sformatf("arb_win%0d", i), {bus.p1_done, bus.p0_done}, exp_w);
    end
`ifndef ROM_ARB_RR_EN
    chk("arb_starve", bus.p1_rdata, 0);
`endif
    chk("arb_rd0", bus.p0_rdata, 8'h01);
    bus.p0_req = 0;
    wait_p(1, 12, c);
    chk("arb_p1lat", c, 5);
    chk("arb_rd1", bus.p1_rdata, 8'h02);
    bus.p1_req = 0;
    step();

    // held request served repeatedly
    do_reset();
    bus.p1_addr = 14'h0ABC; bus.p1_req = 1;
    wait_p(1, 12, c);
    chk("hold_lat", c, 4);
    for (int k = 0; k < 2; k++) begin
      c = -1; lows = 0;
      for (int n = 1; n <= 12; n++) begin
        step();
        if (!bus.busy) lows++;
        if (bus.p1_done) begin
          c = n;
          break;
        end
      end
      chk($sformatf("hold_gap%0d", k), c, 5);
      chk($sformatf("hold_idle%0d", k), lows, 1);
    end
    chk("hold_rd", bus.p1_rdata, 8'hB6);
    chk("hold_rd0", bus.p0_rdata, 0);
    bus.p1_req = 0;
    step(); step();
    chk("hold_end", bus.busy, 0);

    // WAIT_CYCLES = 1 and 15 builds
    do_reset();
    bus1.p0_addr = 14'h2A5A; bus15.p0_addr = 14'h2A5A;
    bus1.p0_req = 1; bus15.p0_req = 1;
    l1 = -1; l15 = -1;
    for (int n = 1; n <= 25; n++) begin
      step();
      if (bus1.p0_done && l1 < 0) begin
        l1 = n; bus1.p0_req = 0;
      end
      if (bus15.p0_done && l15 < 0) begin
        l15 = n; bus15.p0_req = 0;
      end
      if (l1 > 0 && l15 > 0) break;
    end
    chk("w1_lat", l1, 3);
    chk("w15_lat", l15, 17);
    chk("w1_rd", bus1.p0_rdata, 8'h70);
    chk("w15_rd", bus15.p0_rdata, 8'h70);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
